// File: rtl/pk_pkg.sv
// Pass-Keeper shared definitions: scheduler FSM encodings and default datapath width.
// Imported by the command FIFO and the command scheduler.
package pk_pkg;

  localparam int PK_ACC_W = 128;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } pk_state_e;

endpackage

// File: rtl/pk_cmd_fifo.sv
// Pass-Keeper command FIFO: synchronous, DEPTH entries of WIDTH bits, head read from flops.
// Ports: clk, rst (sync, active-high), push/push_data, pop/pop_data, full, empty, count.
module pk_cmd_fifo
  import pk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * PK_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // DEPTH is a power of two, so pointers wrap by overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);

endmodule

// File: rtl/pk_cmd_scheduler.sv
// Pass-Keeper command scheduler: queues host commands, runs them on the core one at a time.
// Ports: cmd_* host in, core_* core side, rsp_* response out, busy/fifo_count status.
// Option: PK_SCHED_TIMEOUT_EN adds a WAIT watchdog driving core_abort / rsp_timeout.
module pk_cmd_scheduler
  import pk_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int ACC_W          = PK_ACC_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ACC_W-1:0]       cmd_account,
  input  logic [ACC_W-1:0]       cmd_password,
  output logic                   core_go,
  output logic [ACC_W-1:0]       core_account,
  output logic [ACC_W-1:0]       core_password,
  input  logic                   core_done,
  input  logic [ACC_W-1:0]       core_password_enc,
  output logic                   core_abort,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ACC_W-1:0]       rsp_password_enc,
  output logic                   rsp_timeout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  pk_state_e state_q, state_d;

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               done_hit;
  logic               expire;
  logic [2*ACC_W-1:0] head;

  assign push = cmd_valid && !full;

  pk_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * ACC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({cmd_account, cmd_password}),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    core_go  = 1'b0;
    done_hit = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_go = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        done_hit = core_done;
        if (core_done || expire) state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operands only change on a pop, so they hold from LAUNCH until the
  // response is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      core_account     <= '0;
      core_password    <= '0;
      rsp_password_enc <= '0;
      rsp_valid        <= 1'b0;
    end else begin
      if (pop) begin
        core_account  <= head[2*ACC_W-1:ACC_W];
        core_password <= head[ACC_W-1:0];
      end
      if (done_hit) begin
        rsp_password_enc <= core_password_enc;
        rsp_valid        <= 1'b1;
      end else if (expire) begin
        rsp_password_enc <= '0;
        rsp_valid        <= 1'b1;
      end else if (state_q == S_RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef PK_SCHED_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst)                     wd_cnt <= '0;
    else if (state_q == S_LAUNCH) wd_cnt <= '0;
    else if (state_q == S_WAIT)   wd_cnt <= wd_cnt + 1'b1;
  end

  // A done arriving on the expiry cycle takes priority.
  assign expire = (state_q == S_WAIT) && !core_done &&
                  (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)           rsp_timeout <= 1'b0;
    else if (done_hit) rsp_timeout <= 1'b0;
    else if (expire)   rsp_timeout <= 1'b1;
  end
`else
  assign expire      = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  assign core_abort = expire;
  assign cmd_ready  = !full;
  assign busy       = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_pk_cmd_scheduler.sv
// Testbench for pk_cmd_scheduler: directed scenarios plus random traffic against a queue model.
// Builds with or without PK_SCHED_TIMEOUT_EN.
module tb_pk_cmd_scheduler;

  localparam int DEPTH = 4;
  localparam int ACC_W = 128;
  localparam int TO    = 16;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  typedef logic [ACC_W-1:0] word_t;
  typedef struct {
    word_t a;
    word_t p;
  } cmd_t;
  typedef struct {
    word_t d;
    logic  to;
  } rsp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  word_t           cmd_account = '0;
  word_t           cmd_password = '0;
  logic            core_go;
  word_t           core_account;
  word_t           core_password;
  logic            core_done = 1'b0;
  word_t           core_password_enc = '0;
  logic            core_abort;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  word_t           rsp_password_enc;
  logic            rsp_timeout;
  logic            busy;
  logic [CNTW-1:0] fifo_count;

  always #5 clk = ~clk;

  pk_cmd_scheduler #(
    .DEPTH          (DEPTH),
    .ACC_W          (ACC_W),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_account       (cmd_account),
    .cmd_password      (cmd_password),
    .core_go           (core_go),
    .core_account      (core_account),
    .core_password     (core_password),
    .core_done         (core_done),
    .core_password_enc (core_password_enc),
    .core_abort        (core_abort),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_password_enc  (rsp_password_enc),
    .rsp_timeout       (rsp_timeout),
    .busy              (busy),
    .fifo_count        (fifo_count)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [ACC_W-1:0] got, logic [ACC_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_t core_fn(word_t a, word_t p);
    word_t k;
    k = {16{8'h98}};
    return a ^ p ^ k;
  endfunction

  function automatic word_t rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference model state
  cmd_t  host_q[$];
  cmd_t  cmd_q[$];
  rsp_t  rsp_q[$];
  int    in_service = 0;
  bit    rsp_pend   = 0;
  word_t op_a, op_p;
  int    cd = 0;
  int    cyc = 0;
  int    go_cyc = 0;
  int    push_cyc = 0;
  bit    lat_arm = 0;
  bit    spur_launch = 0;
  bit    prev_go = 0;
  bit    prev_abort = 0;
  bit    saw_full = 0;
  bit    saw_abort = 0;
  int    n_go = 0;
  int    dly_min = 1;
  int    dly_max = 1;
  int    v_pct = 100;
  int    rdy_mode = 0;
  word_t last_rsp = '0;
  logic  last_to = 1'b0;

  task automatic model_clear();
    host_q.delete();
    cmd_q.delete();
    rsp_q.delete();
    in_service  = 0;
    rsp_pend    = 0;
    cd          = 0;
    lat_arm     = 0;
    spur_launch = 0;
    prev_go     = 0;
    prev_abort  = 0;
  endtask

  task automatic step();
    cmd_t c;
    rsp_t r;
    @(negedge clk);
    cyc++;
    core_done         = 1'b0;
    core_password_enc = '0;

    check("rsp_valid", rsp_valid, rsp_pend);
    if (rsp_valid && rsp_q.size() > 0) begin
      check("rsp_data", rsp_password_enc, rsp_q[0].d);
      check("rsp_timeout", rsp_timeout, rsp_q[0].to);
    end

    if (core_go) begin
      n_go++;
      check("go_pulse", prev_go, 0);
      check("go_overlap", in_service, 0);
      check("go_has_cmd", cmd_q.size() > 0, 1);
      if (cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        check("go_acc", core_account, c.a);
        check("go_pw", core_password, c.p);
        op_a = c.a;
        op_p = c.p;
      end
      in_service = 1;
      go_cyc     = cyc;
      if (lat_arm) begin
        check("go_latency", cyc - push_cyc, 2);
        lat_arm = 0;
      end
      cd = (dly_max == 0) ? 0 : $urandom_range(dly_max, dly_min);
      if (spur_launch) begin
        core_done         = 1'b1;
        core_password_enc = rnd_word();
        spur_launch       = 0;
      end
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        check("op_acc_stable", core_account, op_a);
        check("op_pw_stable", core_password, op_p);
        core_done         = 1'b1;
        core_password_enc = core_fn(op_a, op_p);
        rsp_pend          = 1;
      end
    end
    prev_go = core_go;

    if (core_abort) begin
`ifdef PK_SCHED_TIMEOUT_EN
      check("abort_time", cyc - go_cyc, TO);
      check("abort_pulse", prev_abort, 0);
      saw_abort = 1;
      cd        = 0;
      rsp_pend  = 1;
      if (rsp_q.size() > 0) begin
        r    = rsp_q.pop_front();
        r.d  = '0;
        r.to = 1'b1;
        rsp_q.push_front(r);
      end
`else
      check("abort_tied", core_abort, 0);
`endif
    end
    prev_abort = core_abort;

    check("fifo_count", fifo_count, cmd_q.size());
    check("cmd_ready", cmd_ready, cmd_q.size() < DEPTH);
    check("busy", busy, cmd_q.size() > 0 || in_service > 0);
    if (!cmd_ready) saw_full = 1;

    cmd_valid = 1'b0;
    if (host_q.size() > 0 && $urandom_range(99, 0) < v_pct) begin
      cmd_valid    = 1'b1;
      cmd_account  = host_q[0].a;
      cmd_password = host_q[0].p;
      if (cmd_ready) begin
        c = host_q.pop_front();
        cmd_q.push_back(c);
        r.d  = core_fn(c.a, c.p);
        r.to = 1'b0;
        rsp_q.push_back(r);
        push_cyc = cyc;
      end
    end

    unique case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(3, 0) != 0);
      default: rsp_ready = 1'b0;
    endcase
    if (rsp_ready && rsp_valid) begin
      last_rsp   = rsp_password_enc;
      last_to    = rsp_timeout;
      if (rsp_q.size() > 0) void'(rsp_q.pop_front());
      in_service = 0;
      rsp_pend   = 0;
    end
  endtask

  task automatic do_reset();
    rst               = 1'b1;
    cmd_valid         = 1'b0;
    core_done         = 1'b0;
    rsp_ready         = 1'b0;
    model_clear();
    @(negedge clk);
    cyc++;
    check("rst_go", core_go, 0);
    check("rst_abort", core_abort, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_to", rsp_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_acc", core_account, 0);
    check("rst_pw", core_password, 0);
    check("rst_rsp_data", rsp_password_enc, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ready", cmd_ready, 1);
    rst = 1'b0;
  endtask

  task automatic host_push(word_t a, word_t p);
    cmd_t c;
    c.a = a;
    c.p = p;
    host_q.push_back(c);
  endtask

  task automatic drain(int lim);
    int i;
    i = 0;
    while ((host_q.size() > 0 || cmd_q.size() > 0 || in_service > 0) && i < lim) begin
      step();
      i++;
    end
    check("drain_done", host_q.size() + cmd_q.size() + in_service, 0);
  endtask

  initial begin
    word_t a1, p1;
    int    i;
    repeat (2) @(negedge clk);
    do_reset();

    // Single command, fixed data and latency
    a1 = {16{8'h11}};
    p1 = {16{8'h22}};
    dly_min = 5; dly_max = 5; rdy_mode = 0; v_pct = 100;
    n_go = 0; lat_arm = 1;
    host_push(a1, p1);
    drain(200);
    check("t1_rsp", last_rsp, {16{8'hAB}});
    check("t1_to", last_to, 0);
    check("t1_go_count", n_go, 1);

    // Burst of 5 against a slow core
    dly_min = 30; dly_max = 30; n_go = 0; saw_full = 0;
    for (int k = 0; k < 5; k++) host_push(rnd_word(), rnd_word());
    drain(1000);
    check("t2_full_seen", saw_full, 1);
    check("t2_go_count", n_go, 5);

    // Response stalled with two queued
    dly_min = 3; dly_max = 3; rdy_mode = 2; n_go = 0;
    for (int k = 0; k < 3; k++) host_push(rnd_word(), rnd_word());
    i = 0;
    while (!rsp_pend && i < 50) begin step(); i++; end
    check("t3_rsp_due", rsp_pend, 1);
    repeat (20) step();
    check("t3_valid", rsp_valid, 1);
    check("t3_queued", fifo_count, 2);
    check("t3_go_count", n_go, 1);
    rdy_mode = 0;
    drain(300);

    // Spurious done in IDLE, then in the LAUNCH cycle
    step();
    core_done         = 1'b1;
    core_password_enc = rnd_word();
    step();
    check("t4_idle_rsp", rsp_valid, 0);
    check("t4_idle_busy", busy, 0);
    dly_min = 2; dly_max = 2; spur_launch = 1;
    host_push(rnd_word(), rnd_word());
    drain(100);
    check("t4_spur_fired", spur_launch, 0);

    // Reset mid-WAIT with three queued
    dly_min = 50; dly_max = 50;
    for (int k = 0; k < 4; k++) host_push(rnd_word(), rnd_word());
    i = 0;
    while (!(in_service > 0 && cmd_q.size() == 3) && i < 100) begin step(); i++; end
    check("t5_setup", cmd_q.size(), 3);
    repeat (3) step();
    do_reset();

    // Core never completes
    dly_max = 0; dly_min = 0; saw_abort = 0;
    host_push(rnd_word(), rnd_word());
`ifdef PK_SCHED_TIMEOUT_EN
    i = 0;
    while (!rsp_pend && i < 60) begin step(); i++; end
    check("t6_abort_seen", saw_abort, 1);
    step();
    check("t6_rsp_to", rsp_timeout, 1);
    check("t6_rsp_data", rsp_password_enc, 0);
    drain(50);
`else
    repeat (120) step();
    check("t6_wait_busy", busy, 1);
    check("t6_no_rsp", rsp_valid, 0);
    check("t6_no_abort", core_abort, 0);
    do_reset();
`endif

    // Random traffic
    dly_min = 1; dly_max = 8; rdy_mode = 1; v_pct = 50;
    for (int k = 0; k < 40; k++) host_push(rnd_word(), rnd_word());
    drain(4000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
